// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase controller: main/side road sequencing with a latched
// pedestrian request and a night flash mode, all timing derived from a 1 s tick.
//
// state | meaning
// ------+---------------------------------------------------------------
// MG    | main green, side red; waits for demand once minimum has elapsed
// MY    | main yellow, side red
// AR1   | all red clearance before side green
// SG    | side green, main red; pedestrian walk at start if latched
// SY    | side yellow, main red
// AR2   | all red clearance before main green (also exit path from FL)
// FL    | night flash: both roads blink yellow/off on every tick
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 27_000_000,
    parameter int T_MG     = 10,
    parameter int T_Y      = 3,
    parameter int T_SG     = 6,
    parameter int T_AR     = 1,
    parameter int T_PED    = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [2:0] main_led,
    output logic [2:0] side_led,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_AR2 = 3'd5,
        S_FL  = 3'd6
    } state_t;

    localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int T_M1  = (T_MG > T_Y)  ? T_MG : T_Y;
    localparam int T_M2  = (T_SG > T_AR) ? T_SG : T_AR;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MG_LAST    = TW'(T_MG - 1);
    localparam logic [TW-1:0] Y_LAST     = TW'(T_Y - 1);
    localparam logic [TW-1:0] SG_LAST    = TW'(T_SG - 1);
    localparam logic [TW-1:0] AR_LAST    = TW'(T_AR - 1);
    localparam logic [TW-1:0] PED_LIM    = TW'(T_PED);

    localparam logic [2:0] LAMP_G   = 3'b110;
    localparam logic [2:0] LAMP_Y   = 3'b101;
    localparam logic [2:0] LAMP_R   = 3'b011;
    localparam logic [2:0] LAMP_OFF = 3'b111;

    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_timer;
    state_t        r_state;
    logic          r_ped_lat;
    logic          r_walk_en;
    logic          r_flash;
    logic [2:0]    r_main_led;
    logic [2:0]    r_side_led;
    logic          r_ped_walk;

    logic          w_tick;
    logic [PW-1:0] w_presc_nxt;
    logic [TW-1:0] w_timer_nxt;
    state_t        w_state_nxt;
    logic          w_ped_lat_nxt;
    logic          w_walk_en_nxt;
    logic          w_flash_nxt;
    logic [2:0]    w_main_nxt;
    logic [2:0]    w_side_nxt;
    logic          w_walk_nxt;
    logic          w_demand;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    assign w_demand    = side_req | r_ped_lat;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MG:  if (w_tick && r_timer >= MG_LAST && w_demand) w_state_nxt = S_MY;
            S_MY:  if (w_tick && r_timer == Y_LAST)  w_state_nxt = S_AR1;
            S_AR1: if (w_tick && r_timer == AR_LAST) w_state_nxt = flash_en ? S_FL : S_SG;
            S_SG:  if (w_tick && r_timer == SG_LAST) w_state_nxt = S_SY;
            S_SY:  if (w_tick && r_timer == Y_LAST)  w_state_nxt = S_AR2;
            S_AR2: if (w_tick && r_timer == AR_LAST) w_state_nxt = flash_en ? S_FL : S_MG;
            S_FL:  if (w_tick && !flash_en)          w_state_nxt = S_AR2;
            default: w_state_nxt = S_MG;
        endcase
    end

    // A transition takes priority over the tick: the timer restarts at zero.
    always_comb begin
        w_timer_nxt   = r_timer;
        w_flash_nxt   = r_flash;
        w_walk_en_nxt = r_walk_en;
        w_ped_lat_nxt = r_ped_lat | ped_req;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
            if (w_state_nxt == S_SG) begin
                w_walk_en_nxt = r_ped_lat;
                w_ped_lat_nxt = ped_req;
            end
            if (w_state_nxt == S_FL) begin
                w_flash_nxt = 1'b0;
            end
        end else if (w_tick) begin
            if (r_state == S_FL) begin
                w_flash_nxt = ~r_flash;
            end else if (!(r_state == S_MG && r_timer >= MG_LAST)) begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end
    end

    // Outputs are decoded from next-state values so they update with the state.
    always_comb begin
        w_main_nxt = LAMP_R;
        w_side_nxt = LAMP_R;
        case (w_state_nxt)
            S_MG: w_main_nxt = LAMP_G;
            S_MY: w_main_nxt = LAMP_Y;
            S_SG: w_side_nxt = LAMP_G;
            S_SY: w_side_nxt = LAMP_Y;
            S_FL: begin
                w_main_nxt = w_flash_nxt ? LAMP_OFF : LAMP_Y;
                w_side_nxt = w_flash_nxt ? LAMP_OFF : LAMP_Y;
            end
            default: ;
        endcase
        w_walk_nxt = (w_state_nxt == S_SG) && w_walk_en_nxt && (w_timer_nxt < PED_LIM);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_presc    <= '0;
            r_timer    <= '0;
            r_state    <= S_MG;
            r_ped_lat  <= 1'b0;
            r_walk_en  <= 1'b0;
            r_flash    <= 1'b0;
            r_main_led <= LAMP_G;
            r_side_led <= LAMP_R;
            r_ped_walk <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_timer    <= w_timer_nxt;
            r_state    <= w_state_nxt;
            r_ped_lat  <= w_ped_lat_nxt;
            r_walk_en  <= w_walk_en_nxt;
            r_flash    <= w_flash_nxt;
            r_main_led <= w_main_nxt;
            r_side_led <= w_side_nxt;
            r_ped_walk <= w_walk_nxt;
        end
    end

    assign main_led = r_main_led;
    assign side_led = r_side_led;
    assign ped_walk = r_ped_walk;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random stimulus, each
// cycle compared against a tick-counting reference model of the phase rules.
module tb_traffic_phase_ctrl;

    localparam int TD = 4, T_MG = 3, T_Y = 2, T_SG = 4, T_AR = 1, T_PED = 2;
    localparam logic [2:0] G = 3'b110, Y = 3'b101, R = 3'b011, OFF = 3'b111;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] main_led, side_led, phase;
    logic       ped_walk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase code, ticks completed in phase, cycles since reset.
    int m_phase = 0, m_ticks = 0, m_cyc = 0;
    bit m_lat = 0, m_walk_en = 0, m_flash = 0;
    int         dur[6]      = '{T_MG, T_Y, T_AR, T_SG, T_Y, T_AR};
    int         succ[6]     = '{1, 2, 3, 4, 5, 0};
    logic [2:0] main_tab[6] = '{G, Y, R, R, R, R};
    logic [2:0] side_tab[6] = '{R, R, R, G, Y, R};
    int         exp_dur[6]  = '{12, 8, 4, 16, 8, 4};

    traffic_phase_ctrl #(
        .TICK_DIV(TD), .T_MG(T_MG), .T_Y(T_Y), .T_SG(T_SG), .T_AR(T_AR), .T_PED(T_PED)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .side_req(side_req),
        .ped_req (ped_req),
        .flash_en(flash_en),
        .main_led(main_led),
        .side_led(side_led),
        .ped_walk(ped_walk),
        .phase   (phase)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_update();
        int n, nxt;
        bit tick;
        if (sys_rst) begin
            m_phase = 0; m_ticks = 0; m_cyc = 0;
            m_lat = 0; m_walk_en = 0; m_flash = 0;
            return;
        end
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        nxt = m_phase;
        if (tick) begin
            n = m_ticks + 1;
            if (m_phase == 6) begin
                if (!flash_en) nxt = 5;
            end else if (n >= dur[m_phase] && (m_phase != 0 || side_req || m_lat)) begin
                nxt = succ[m_phase];
                if ((m_phase == 2 || m_phase == 5) && flash_en) nxt = 6;
            end
        end
        if (nxt != m_phase) begin
            if (nxt == 3) begin
                m_walk_en = m_lat;
                m_lat = ped_req;
            end else begin
                m_lat = m_lat | ped_req;
            end
            if (nxt == 6) m_flash = 0;
            m_ticks = 0;
            m_phase = nxt;
        end else begin
            m_lat = m_lat | ped_req;
            if (tick) begin
                m_ticks++;
                if (m_phase == 6) m_flash = !m_flash;
            end
        end
    endtask

    task automatic cyc();
        logic [2:0] em, es;
        logic       ew;
        @(posedge sys_clk);
        m_update();
        #1;
        if (m_phase == 6) begin
            em = m_flash ? OFF : Y;
            es = em;
        end else begin
            em = main_tab[m_phase];
            es = side_tab[m_phase];
        end
        ew = (m_phase == 3) && m_walk_en && (m_ticks < T_PED);
        chk("phase", phase, m_phase);
        chk("main_led", main_led, em);
        chk("side_led", side_led, es);
        chk("ped_walk", ped_walk, ew);
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        repeat (n) cyc();
        sys_rst = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int bound);
        int k = 0;
        while (phase !== p[2:0] && k < bound) begin
            cyc();
            k++;
        end
        chk($sformatf("reach_phase%0d", p), phase, p);
    endtask

    initial begin
        int cnt, k;

        // Reset values and idle hold with no demand.
        do_reset(3);
        chk("rst_phase", phase, 0);
        chk("rst_main", main_led, G);
        chk("rst_side", side_led, R);
        chk("rst_walk", ped_walk, 0);
        repeat (100) cyc();
        chk("idle_phase", phase, 0);
        chk("idle_side", side_led, R);

        // Continuous side demand: full 52-clock cycle, twice.
        side_req = 1'b1;
        do_reset(2);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 6; p++) begin
                cnt = 0;
                while (phase === p[2:0] && cnt < 100) begin
                    cnt++;
                    cyc();
                end
                chk($sformatf("dur_r%0d_p%0d", r, p), cnt, exp_dur[p]);
            end
        end
        chk("back_to_mg", phase, 0);

        // Single ped pulse in MG: MY at next tick, walk for two ticks in SG.
        side_req = 1'b0;
        do_reset(2);
        repeat (20) cyc();
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        cnt = 0;
        while (phase === 3'd0 && cnt < 50) begin
            cyc();
            cnt++;
        end
        chk("ped_to_my", cnt, 3);
        wait_phase(3, 100);
        cnt = 0;
        k = 0;
        while (phase === 3'd3 && k < 100) begin
            if (ped_walk) cnt++;
            cyc();
            k++;
        end
        chk("walk_cycles", cnt, 8);

        // Flash mode requested during MY.
        side_req = 1'b1;
        do_reset(2);
        wait_phase(1, 100);
        flash_en = 1'b1;
        wait_phase(6, 100);
        for (int i = 0; i < 16; i++) begin
            chk("flash_main", main_led, ((i / 4) % 2) ? OFF : Y);
            chk("flash_side", side_led, ((i / 4) % 2) ? OFF : Y);
            cyc();
        end
        flash_en = 1'b0;
        wait_phase(5, 50);
        cnt = 0;
        while (phase === 3'd5 && cnt < 50) begin
            chk("ar2_main", main_led, R);
            chk("ar2_side", side_led, R);
            cnt++;
            cyc();
        end
        chk("ar2_cycles", cnt, 4);
        chk("after_ar2", phase, 0);

        // Reset pulse mid-SG with the ped latch set again.
        side_req = 1'b0;
        do_reset(2);
        repeat (5) cyc();
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        wait_phase(3, 100);
        repeat (2) cyc();
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
        chk("midrst_phase", phase, 0);
        chk("midrst_main", main_led, G);
        chk("midrst_side", side_led, R);
        chk("midrst_walk", ped_walk, 0);
        repeat (40) cyc();
        chk("latch_cleared", phase, 0);

        // Random traffic against the model.
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) side_req = ~side_req;
            ped_req  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) flash_en = ~flash_en;
            sys_rst  = ($urandom_range(0, 799) == 0);
            cyc();
        end
        sys_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
